// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock input, restart request and status outputs of the PLL sequencer
interface pll_reset_sequencer_if #(parameter int CNT_W = 8);
  logic pll_locked;
  logic restart_req;
  logic pll_rst;
  logic ready;
  logic fail;
  logic [2:0] state;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] lost_count;
  modport master (
    output pll_locked, restart_req,
    input pll_rst, ready, fail, state, timeout_count, lost_count
  );
  modport slave (
    input pll_locked, restart_req,
    output pll_rst, ready, fail, state, timeout_count, lost_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds PLL reset, waits for and qualifies lock, retries on timeout, releases ready
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 8
) (
  input logic clk,
  input logic rst_n,
  pll_reset_sequencer_if.slave bus
);
  localparam int TMAX = (LOCK_TIMEOUT > STABLE_CYCLES)
    ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
    : ((STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES);
  localparam int TW = $clog2(TMAX);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retries_q, retries_d, retries_inc;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, lcnt_q, lcnt_d;
  logic [1:0] sync_q;
  logic locked_s;
  logic pll_rst_q, pll_rst_d, ready_q, ready_d, fail_q, fail_d;
  assign locked_s    = sync_q[1];
  assign retries_inc = retries_q + 1'b1;
  // Next-state, timer, retry and status-counter logic; restart_req overrides every event
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    tcnt_d    = tcnt_q;
    lcnt_d    = lcnt_q;
    if (bus.restart_req) begin
      state_d   = RESET;
      retries_d = '0;
    end else begin
      case (state_q)
        RESET:     state_d = (timer_q == TW'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET;
        WAIT_LOCK: begin
          if (locked_s) state_d = STABLE;
          else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            tcnt_d    = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
            retries_d = retries_inc;
            state_d   = (retries_inc == RW'(MAX_RETRIES)) ? FAIL : RESET;
          end
        end
        STABLE: begin
          if (!locked_s) state_d = WAIT_LOCK;
          else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
            state_d   = RUN;
            retries_d = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            lcnt_d  = (lcnt_q == '1) ? lcnt_q : lcnt_q + 1'b1;
            state_d = RESET;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = RESET;
      endcase
    end
    timer_d   = (bus.restart_req || state_d != state_q) ? '0 : timer_q + 1'b1;
    pll_rst_d = (state_d == RESET) || (state_d == FAIL);
    ready_d   = state_d == RUN;
    fail_d    = state_d == FAIL;
  end
  // State, counters, registered outputs and the lock synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET;
      timer_q   <= '0;
      retries_q <= '0;
      tcnt_q    <= '0;
      lcnt_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      tcnt_q    <= tcnt_d;
      lcnt_q    <= lcnt_d;
      sync_q    <= {sync_q[0], bus.pll_locked};
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end
  assign bus.state         = state_q;
  assign bus.pll_rst       = pll_rst_q;
  assign bus.ready         = ready_q;
  assign bus.fail          = fail_q;
  assign bus.timeout_count = tcnt_q;
  assign bus.lost_count    = lcnt_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios for the PLL reset sequencer with hand-computed expectations
module tb_pll_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  pll_reset_sequencer_if #(.CNT_W(4)) bus();
  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(4)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    bus.pll_locked = 1'b0;
    bus.restart_req = 1'b0;
    rst_n = 1'b0;
    tick(3);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if ({bus.pll_rst, bus.ready, bus.fail} !== 3'b100) begin errors++; $display("FAIL reset_flags got=%b exp=100", {bus.pll_rst, bus.ready, bus.fail}); end
    checks++; if ({bus.timeout_count, bus.lost_count} !== 8'h00) begin errors++; $display("FAIL reset_counts got=%h exp=00", {bus.timeout_count, bus.lost_count}); end
    rst_n = 1'b1;
  endtask
  task automatic test_bringup;
    tick(3);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd0, 1'b1}) begin errors++; $display("FAIL bringup_rst3 got=%0d/%b exp=0/1", bus.state, bus.pll_rst); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin errors++; $display("FAIL bringup_wait got=%0d/%b exp=1/0", bus.state, bus.pll_rst); end
    tick(6);
    bus.pll_locked = 1'b1;
    tick(2);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL bringup_sync_latency got=%0d exp=1", bus.state); end
    tick(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL bringup_stable got=%0d exp=2", bus.state); end
    tick(7);
    checks++; if ({bus.state, bus.ready} !== {3'd2, 1'b0}) begin errors++; $display("FAIL bringup_stable7 got=%0d/%b exp=2/0", bus.state, bus.ready); end
    tick(1);
    checks++; if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin errors++; $display("FAIL bringup_run got=%0d/%b exp=3/1", bus.state, bus.ready); end
    checks++; if ({bus.timeout_count, bus.lost_count} !== 8'h00) begin errors++; $display("FAIL bringup_counts got=%h exp=00", {bus.timeout_count, bus.lost_count}); end
  endtask
  task automatic test_loss_in_run;
    bus.pll_locked = 1'b0;
    tick(2);
    checks++; if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin errors++; $display("FAIL loss_before got=%0d/%b exp=3/1", bus.state, bus.ready); end
    tick(1);
    checks++; if ({bus.state, bus.ready, bus.pll_rst} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL loss_edge got=%0d/%b/%b exp=0/0/1", bus.state, bus.ready, bus.pll_rst); end
    checks++; if (bus.lost_count !== 4'd1) begin errors++; $display("FAIL loss_count got=%0d exp=1", bus.lost_count); end
    tick(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL loss_rst_hold got=%b exp=1", bus.pll_rst); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin errors++; $display("FAIL loss_rst_len got=%0d/%b exp=1/0", bus.state, bus.pll_rst); end
    bus.pll_locked = 1'b1;
    tick(3);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL loss_relock got=%0d exp=2", bus.state); end
  endtask
  task automatic test_glitch;
    tick(5);
    bus.pll_locked = 1'b0;
    tick(2);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL glitch_hold got=%0d exp=2", bus.state); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst, bus.ready} !== {3'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL glitch_back got=%0d/%b/%b exp=1/0/0", bus.state, bus.pll_rst, bus.ready); end
    bus.pll_locked = 1'b1;
    tick(2);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin errors++; $display("FAIL glitch_wait got=%0d/%b exp=1/0", bus.state, bus.pll_rst); end
    tick(1);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL glitch_restable got=%0d exp=2", bus.state); end
    tick(7);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL glitch_requal got=%b exp=0", bus.ready); end
    tick(1);
    checks++; if ({bus.state, bus.ready} !== {3'd3, 1'b1}) begin errors++; $display("FAIL glitch_run got=%0d/%b exp=3/1", bus.state, bus.ready); end
    checks++; if ({bus.timeout_count, bus.lost_count} !== 8'h01) begin errors++; $display("FAIL glitch_counts got=%h exp=01", {bus.timeout_count, bus.lost_count}); end
  endtask
  task automatic test_timeout_fail;
    bus.pll_locked = 1'b0;
    tick(3);
    checks++; if ({bus.state, bus.lost_count} !== {3'd0, 4'd2}) begin errors++; $display("FAIL to_loss got=%0d/%0d exp=0/2", bus.state, bus.lost_count); end
    tick(4);
    tick(31);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL to_window1 got=%0d exp=1", bus.state); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst, bus.timeout_count} !== {3'd0, 1'b1, 4'd1}) begin errors++; $display("FAIL to_retry1 got=%0d/%b/%0d exp=0/1/1", bus.state, bus.pll_rst, bus.timeout_count); end
    tick(3);
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL to_pulse2 got=%b exp=1", bus.pll_rst); end
    tick(1);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd1, 1'b0}) begin errors++; $display("FAIL to_wait2 got=%0d/%b exp=1/0", bus.state, bus.pll_rst); end
    tick(32);
    checks++; if ({bus.state, bus.fail, bus.pll_rst, bus.ready, bus.timeout_count} !== {3'd4, 1'b1, 1'b1, 1'b0, 4'd2}) begin errors++; $display("FAIL to_fail got=%0d/%b/%b/%b/%0d exp=4/1/1/0/2", bus.state, bus.fail, bus.pll_rst, bus.ready, bus.timeout_count); end
    tick(40);
    checks++; if ({bus.state, bus.fail, bus.pll_rst} !== {3'd4, 1'b1, 1'b1}) begin errors++; $display("FAIL to_sticky got=%0d/%b/%b exp=4/1/1", bus.state, bus.fail, bus.pll_rst); end
    bus.restart_req = 1'b1;
    tick(1);
    bus.restart_req = 1'b0;
    checks++; if ({bus.state, bus.fail, bus.pll_rst} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL to_restart got=%0d/%b/%b exp=0/0/1", bus.state, bus.fail, bus.pll_rst); end
    tick(4);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL to_fresh got=%0d exp=1", bus.state); end
    tick(32);
    checks++; if ({bus.state, bus.timeout_count} !== {3'd0, 4'd3}) begin errors++; $display("FAIL to_retries_cleared got=%0d/%0d exp=0/3", bus.state, bus.timeout_count); end
  endtask
  task automatic test_simultaneous;
    tick(4);
    tick(31);
    bus.restart_req = 1'b1;
    tick(1);
    bus.restart_req = 1'b0;
    checks++; if ({bus.state, bus.timeout_count} !== {3'd0, 4'd3}) begin errors++; $display("FAIL sim_timeout got=%0d/%0d exp=0/3", bus.state, bus.timeout_count); end
    tick(4);
    bus.pll_locked = 1'b1;
    tick(11);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL sim_run got=%0d exp=3", bus.state); end
    bus.pll_locked = 1'b0;
    tick(2);
    bus.restart_req = 1'b1;
    tick(1);
    bus.restart_req = 1'b0;
    checks++; if ({bus.state, bus.ready, bus.lost_count} !== {3'd0, 1'b0, 4'd2}) begin errors++; $display("FAIL sim_loss got=%0d/%b/%0d exp=0/0/2", bus.state, bus.ready, bus.lost_count); end
  endtask
  task automatic test_saturation;
    int n;
    for (int i = 0; i < 20; i++) begin
      bus.pll_locked = 1'b1;
      n = 0;
      while (bus.state !== 3'd3 && n < 100) begin tick(1); n++; end
      checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL sat_run%0d got=%0d exp=3", i, bus.state); end
      bus.pll_locked = 1'b0;
      n = 0;
      while (bus.state !== 3'd0 && n < 100) begin tick(1); n++; end
    end
    checks++; if (bus.lost_count !== 4'd15) begin errors++; $display("FAIL sat_lost got=%0d exp=15", bus.lost_count); end
  endtask
  task automatic test_async_reset;
    bus.pll_locked = 1'b1;
    tick(8);
    checks++; if ({bus.state, bus.pll_rst} !== {3'd2, 1'b0}) begin errors++; $display("FAIL ar_stable got=%0d/%b exp=2/0", bus.state, bus.pll_rst); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.state, bus.pll_rst, bus.ready, bus.fail} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL ar_flags got=%0d/%b/%b/%b exp=0/1/0/0", bus.state, bus.pll_rst, bus.ready, bus.fail); end
    checks++; if ({bus.timeout_count, bus.lost_count} !== 8'h00) begin errors++; $display("FAIL ar_counts got=%h exp=00", {bus.timeout_count, bus.lost_count}); end
  endtask
  initial begin
    test_reset();
    test_bringup();
    test_loss_in_run();
    test_glitch();
    test_timeout_fail();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the core PLL: holds its reset, waits for lock, qualifies lock stability, then releases a system-ready flag.
- Recovers automatically from lock timeout and loss of lock, with a bounded retry count and a sticky fail state.
- Runs on the free-running 74.25 MHz reference clock, the same clock that feeds the PLL.
- `ready` drives the per-domain reset synchronizers, which are outside this block.

Parameters:
RST_CYCLES, 16, cycles `pll_rst` is held high per attempt (>=2)
LOCK_TIMEOUT, 65536, cycles to wait for synchronized lock before retrying (>=2)
STABLE_CYCLES, 1024, cycles lock must stay continuously high before `ready` (>=2)
MAX_RETRIES, 8, consecutive lock timeouts before entering FAIL (>=1)
CNT_W, 8, width of the status counters

Ports:
clk  in  1  free-running reference clock (same net as PLL refclk)
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output, asynchronous to clk
restart_req  in  1  single-cycle pulse requesting a full re-lock
pll_rst  out  1  active-high reset to the PLL
ready  out  1  high while the PLL is locked and qualified
fail  out  1  sticky: retries exhausted
state  out  3  current state encoding, for debug
timeout_count  out  CNT_W  saturating count of lock timeouts
lost_count  out  CNT_W  saturating count of lock losses while in RUN

Behaviour:
- Reset (rst_n=0, asynchronous): state=RESET, pll_rst=1, ready=0, fail=0, timer=0, retries=0, both counters=0, sync flops=0.
- Lock sync: pll_locked passes through a 2-flop synchronizer giving locked_s. Latency is 2 clk edges; all decisions use locked_s only.
- State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; other codes go to RESET.
- Single timer: cleared on every state transition, otherwise increments each cycle.
- Outputs pll_rst, ready and fail are flops loaded from next-state, so they change on the same edge as state.
  - pll_rst=1 in RESET and FAIL.
  - ready=1 only in RUN.
  - fail=1 only in FAIL.
- RESET: after exactly RST_CYCLES cycles (timer==RST_CYCLES-1) -> WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 -> STABLE.
  - Else if timer==LOCK_TIMEOUT-1: timeout_count+=1 (saturating) and retries+=1. If the new retries==MAX_RETRIES -> FAIL, else -> RESET.
- STABLE:
  - locked_s=0 -> WAIT_LOCK (glitch; no counter change; the timeout window restarts).
  - timer==STABLE_CYCLES-1 with locked_s=1 -> RUN; retries cleared.
- RUN: locked_s=0 -> lost_count+=1 (saturating) and -> RESET. ready falls on that same edge.
- FAIL: held indefinitely; leaves only via restart_req or rst_n.
- restart_req (any state, including RESET):
  - Next state RESET; timer and retries cleared; fail cleared.
  - No counter increments that cycle; it overrides a simultaneous timeout or lock loss.
- Counters saturate at 2^CNT_W-1 and never wrap; cleared only by rst_n.
- rst_n asserted mid-sequence: immediate return to reset values, including pll_rst=1 with no glitch low.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=4.
1. Normal bring-up: release rst_n, raise pll_locked 10 cycles later and hold it -> pll_rst high exactly 4 cycles; WAIT_LOCK until locked_s (2 cycles after the input); ready rises 8 cycles after STABLE entry; counters stay 0.
2. Lock timeout and fail: hold pll_locked=0 -> two 32-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_rst pulse; timeout_count=2; state=4, fail=1, pll_rst stuck high. A restart_req pulse -> fail=0, state=0, fresh sequence.
3. Stability glitch: in STABLE at timer=5, drop pll_locked for 3 cycles -> back to WAIT_LOCK with no pll_rst pulse; re-lock -> full 8-cycle qualification, then ready; counters unchanged.
4. Loss in RUN: drop pll_locked while ready=1 -> ready falls 3 edges later (2 sync + 1); lost_count=1; pll_rst pulses 4 cycles; re-lock -> ready again.
5. Simultaneous events: restart_req asserted on the same cycle locked_s falls in RUN -> state RESET, lost_count unchanged. Also pulse restart_req at WAIT_LOCK timer=31 -> timeout_count unchanged.
6. Saturation and async reset: force 20 RUN losses -> lost_count stays at 15. Assert rst_n mid-STABLE -> pll_rst=1, ready=0 and all counters 0 without waiting for a clk edge.
